// File: rtl/a_sync_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Package  : a_sync_pkg
// Purpose  : Shared types and constants for the clocked-to-async token source.
// Revision : 1.0 - initial release
// ============================================================================
package a_sync_pkg;

  // Token source FSM states
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_REQ   = 2'd2,
    S_RTZ   = 2'd3
  } a_src_state_t;

  // Width of the completed-token counter
  localparam int SENT_W = 16;

  // Counter width able to hold values 0..v-1, never less than one bit
  function automatic int cnt_width(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/a_sync_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : a_sync_fifo
// Purpose  : Small synchronous FIFO, flop array, head word combinationally
//            visible on dout. Pointers carry one extra wrap bit so that
//            full and empty are distinguished by the MSB compare.
// Revision : 1.0 - initial release
// ============================================================================
module a_sync_fifo #(
  parameter int N     = 1,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [N-1:0] din,
  output logic         full,
  input  logic         pop,
  output logic [N-1:0] dout,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [N-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic         w_push;
  logic         w_pop;

  // Refuse writes when full and reads when empty regardless of the caller
  assign w_push = push & ~full;
  assign w_pop  = pop  & ~empty;

  assign empty = (r_wptr == r_rptr);
  assign full  = (r_wptr[AW] != r_rptr[AW]) &&
                 (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign dout  = r_mem[r_rptr[AW-1:0]];

  // Storage array; contents need no reset because empty masks them
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= din;
    end
  end

  // Read/write pointers with wrap bit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/a_sync_src.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : a_sync_src
// Purpose  : Clocked valid/ready to 4-phase bundled-data bridge. Words are
//            buffered in a FIFO and launched as r_o/d_o tokens; the async
//            acknowledge a_o is synchronised before the FSM looks at it.
// Revision : 1.0 - initial release
// ============================================================================
module a_sync_src
  import a_sync_pkg::*;
#(
  parameter int   N         = 1,
  parameter logic Rpol      = 1'b0,
  parameter int   DEPTH     = 4,
  parameter int   SETUP_CYC = 1,
  parameter int   SYNC_FF   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      in_data,
  output logic              r_o,
  input  logic              a_o,
  output logic [N-1:0]      d_o,
  output logic              busy,
  output logic [SENT_W-1:0] sent
);

  localparam int               CNT_W    = cnt_width(SETUP_CYC);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETUP_CYC - 1);

  // FIFO interface
  logic         w_push;
  logic         w_pop;
  logic         w_full;
  logic         w_empty;
  logic [N-1:0] w_head;

  // Synchroniser and FSM registers
  logic [SYNC_FF-1:0] r_sync;
  logic               w_a_s;
  a_src_state_t       r_state;
  a_src_state_t       w_state_nxt;
  logic               r_ro;
  logic               w_ro_nxt;
  logic [N-1:0]       r_do;
  logic [N-1:0]       w_do_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [SENT_W-1:0]  r_sent;
  logic [SENT_W-1:0]  w_sent_nxt;

  // Held low during reset so the producer never sees a window to push into
  assign in_ready = ~rst & ~w_full;
  assign w_push   = in_valid & in_ready;

  a_sync_fifo #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .din   (in_data),
    .full  (w_full),
    .pop   (w_pop),
    .dout  (w_head),
    .empty (w_empty)
  );

  // Bring the asynchronous acknowledge into the clk domain
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= {SYNC_FF{Rpol}};
    end else begin
      r_sync <= {r_sync[SYNC_FF-2:0], a_o};
    end
  end

  assign w_a_s = r_sync[SYNC_FF-1];

  // Next-state logic; d_o is only ever reloaded on entry to SETUP so the
  // bundled data is stable across the whole four-phase handshake
  always_comb begin
    w_state_nxt = r_state;
    w_ro_nxt    = r_ro;
    w_do_nxt    = r_do;
    w_cnt_nxt   = r_cnt;
    w_sent_nxt  = r_sent;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_do_nxt    = w_head;
          w_cnt_nxt   = CNT_LOAD;
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        if (r_cnt == '0) begin
          w_ro_nxt    = ~Rpol;
          w_state_nxt = S_REQ;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_REQ: begin
        if (w_a_s == ~Rpol) begin
          w_ro_nxt    = Rpol;
          w_state_nxt = S_RTZ;
        end
      end
      S_RTZ: begin
        if (w_a_s == Rpol) begin
          w_sent_nxt = r_sent + SENT_W'(1);
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_do_nxt    = w_head;
            w_cnt_nxt   = CNT_LOAD;
            w_state_nxt = S_SETUP;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers; r_o comes straight from a flop so it is glitch-free
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ro    <= Rpol;
      r_do    <= '0;
      r_cnt   <= '0;
      r_sent  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ro    <= w_ro_nxt;
      r_do    <= w_do_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sent  <= w_sent_nxt;
    end
  end

  assign r_o  = r_ro;
  assign d_o  = r_do;
  assign sent = r_sent;
  assign busy = (r_state != S_IDLE) | ~w_empty;

endmodule
`default_nettype wire

// File: tb/tb_a_sync_src.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_a_sync_src
// Purpose  : Self-checking bench for a_sync_src. Two instances: dut0 with
//            Rpol=0/SETUP_CYC=1 and dut1 with Rpol=1/SETUP_CYC=3, each
//            answered by a randomly delayed async acknowledge model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_a_sync_src;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst;
  logic [1:0]  in_valid;
  logic [1:0]  in_ready;
  logic [1:0]  r_o;
  logic [1:0]  busy;
  logic [1:0]  en;
  logic        a_o0;
  logic        a_o1;
  logic [7:0]  in_data [2];
  logic [7:0]  d_o     [2];
  logic [15:0] sent    [2];

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic mon_en   = 1'b0;

  a_sync_src #(.N(8), .Rpol(1'b0), .DEPTH(4), .SETUP_CYC(1), .SYNC_FF(2)) u_dut0 (
    .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .r_o(r_o[0]), .a_o(a_o0), .d_o(d_o[0]),
    .busy(busy[0]), .sent(sent[0])
  );

  a_sync_src #(.N(8), .Rpol(1'b1), .DEPTH(4), .SETUP_CYC(3), .SYNC_FF(2)) u_dut1 (
    .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .r_o(r_o[1]), .a_o(a_o1), .d_o(d_o[1]),
    .busy(busy[1]), .sent(sent[1])
  );

  function automatic logic rp(input int d);
    return (d == 1);
  endfunction

  function automatic int setup_of(input int d);
    return (d == 1) ? 3 : 1;
  endfunction

  function automatic logic get_a(input int d);
    return (d == 1) ? a_o1 : a_o0;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Async responders: a_o follows r_o after 0-50 ns, independent of clk
  initial begin
    a_o0 = 1'b0;
    forever begin
      wait (en[0] && (a_o0 !== r_o[0]) && (r_o[0] !== 1'bx));
      #($urandom_range(0, 50));
      if (en[0]) a_o0 = r_o[0];
    end
  end

  initial begin
    a_o1 = 1'b1;
    forever begin
      wait (en[1] && (a_o1 !== r_o[1]) && (r_o[1] !== 1'bx));
      #($urandom_range(0, 50));
      if (en[1]) a_o1 = r_o[1];
    end
  end

  // Monitor: scoreboard pop on each request edge, setup time and data stability
  initial begin
    logic [1:0] prev_r;
    logic [7:0] prev_d [2];
    int         stable [2];
    logic [7:0] exp_w;
    prev_r = '0;
    stable[0] = 0;
    stable[1] = 0;
    prev_d[0] = '0;
    prev_d[1] = '0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (mon_en) begin
          if (d_o[d] !== prev_d[d]) begin
            stable[d] = 1;
            check($sformatf("dut%0d_d_o_change_ack_idle", d), 32'(get_a(d)), 32'(rp(d)));
          end else begin
            stable[d]++;
          end
          if (r_o[d] !== rp(d) && prev_r[d] === rp(d)) begin
            check($sformatf("dut%0d_setup_cycles_ok", d),
                  32'((stable[d] - 1) >= setup_of(d)), 32'd1);
            if (d == 0 ? (q0.size() == 0) : (q1.size() == 0)) begin
              check($sformatf("dut%0d_unexpected_token", d), 32'(d_o[d]), 32'hFFFF_FFFF);
            end else begin
              exp_w = (d == 0) ? q0.pop_front() : q1.pop_front();
              check($sformatf("dut%0d_token_data", d), 32'(d_o[d]), 32'(exp_w));
            end
          end
        end
        prev_r[d] = r_o[d];
        prev_d[d] = d_o[d];
      end
    end
  end

  // Called at a negedge; returns at the negedge after the transfer edge
  task automatic push_word(input int d, input logic [7:0] w);
    int t = 0;
    while (!in_ready[d] && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready[d]) begin
      check($sformatf("dut%0d_push_timeout", d), 32'd0, 32'd1);
    end else begin
      in_valid[d] = 1'b1;
      in_data[d]  = w;
      if (d == 0) q0.push_back(w);
      else        q1.push_back(w);
      @(negedge clk);
      in_valid[d] = 1'b0;
    end
  endtask

  task automatic wait_sent(input int d, input logic [15:0] tgt, input string tag);
    int t = 0;
    while (sent[d] !== tgt && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check(tag, 32'(sent[d]), 32'(tgt));
  endtask

  task automatic do_reset(input int d);
    rst[d] = 1'b1;
    @(negedge clk);
    rst[d] = 1'b0;
    if (d == 0) q0.delete();
    else        q1.delete();
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst        = 2'b11;
    in_valid   = 2'b00;
    in_data[0] = '0;
    in_data[1] = '0;
    en         = 2'b11;

    // 1 Reset state
    repeat (3) @(negedge clk);
    check("rst_r_o",      32'(r_o[0]),      32'd0);
    check("rst_d_o",      32'(d_o[0]),      32'd0);
    check("rst_sent",     32'(sent[0]),     32'd0);
    check("rst_busy",     32'(busy[0]),     32'd0);
    check("rst_in_ready", 32'(in_ready[0]), 32'd0);
    check("rst_r_o_rpol1", 32'(r_o[1]),     32'd1);
    rst    = 2'b00;
    mon_en = 1'b1;
    @(negedge clk);
    check("in_ready_after_rst0", 32'(in_ready[0]), 32'd1);
    check("in_ready_after_rst1", 32'(in_ready[1]), 32'd1);

    // 2 Single word latency and completion
    push_word(0, 8'hA5);
    check("t2_r_o_edge_k", 32'(r_o[0]), 32'd0);
    @(negedge clk);
    check("t2_d_o_edge_k1", 32'(d_o[0]), 32'hA5);
    check("t2_r_o_edge_k1", 32'(r_o[0]), 32'd0);
    @(negedge clk);
    check("t2_r_o_edge_k2", 32'(r_o[0]), 32'd1);
    wait_sent(0, 16'd1, "t2_sent");
    check("t2_busy",   32'(busy[0]), 32'd0);
    check("t2_d_o_kept", 32'(d_o[0]), 32'hA5);

    // 3 Fill with ack held idle, then drain in order
    do_reset(0);
    @(negedge clk);
    en[0] = 1'b0;
    for (int i = 1; i <= 5; i++) push_word(0, 8'(i));
    check("t3_in_ready_full", 32'(in_ready[0]), 32'd0);
    check("t3_busy_full",     32'(busy[0]),     32'd1);
    check("t3_r_o_stuck",     32'(r_o[0]),      32'd1);
    check("t3_sent_zero",     32'(sent[0]),     32'd0);
    en[0] = 1'b1;
    wait_sent(0, 16'd5, "t3_sent");
    check("t3_sb_drained", 32'(q0.size()), 32'd0);
    check("t3_busy_done",  32'(busy[0]),   32'd0);

    // 4/5 Rpol=1, SETUP_CYC=3, 16 random words
    check("t4_idle_r_o", 32'(r_o[1]), 32'd1);
    check("t4_idle_a_o", 32'(a_o1),   32'd1);
    for (int i = 0; i < 16; i++) push_word(1, 8'($urandom));
    wait_sent(1, 16'd16, "t4_sent");
    check("t4_sb_drained", 32'(q1.size()), 32'd0);
    check("t4_busy_done",  32'(busy[1]),   32'd0);

    // 6 Reset mid-token with two words queued
    en[0] = 1'b0;
    push_word(0, 8'h11);
    push_word(0, 8'h22);
    push_word(0, 8'h33);
    t = 0;
    while (r_o[0] !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("t6_in_req", 32'(r_o[0]), 32'd1);
    rst[0] = 1'b1;
    @(negedge clk);
    check("t6_rst_r_o",  32'(r_o[0]),  32'd0);
    check("t6_rst_busy", 32'(busy[0]), 32'd0);
    check("t6_rst_sent", 32'(sent[0]), 32'd0);
    q0.delete();
    rst[0] = 1'b0;
    en[0]  = 1'b1;
    repeat (2) @(negedge clk);
    push_word(0, 8'h3C);
    wait_sent(0, 16'd1, "t6_fresh_sent");
    check("t6_fresh_d_o", 32'(d_o[0]),   32'h3C);
    check("t6_sb_drained", 32'(q0.size()), 32'd0);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
